ledr_seq_ctrl: RTL

LEDR_SEQ_CTRL -- requirements
Module: ledr_seq_ctrl

---
 rtl/ledr_seq_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/ledr_seq_ctrl.sv
// LED pattern sequencer that writes an 18-bit pattern to a PIO register over Avalon-MM.
// Define LEDR_SEQ_READBACK_EN to add a read-back/compare stage after every write.
module ledr_seq_ctrl #(
  parameter int unsigned DWELL_CYCLES = 32'd50000000,
  parameter logic [1:0]  PIO_ADDR     = 2'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [1:0]  mode,
  input  logic [17:0] seed,
  output logic [1:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic        avm_read_n,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic [17:0] pattern,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DWELL = 2'd3
  } state_t;

  localparam logic        DIR_LEFT   = 1'b0;
  localparam logic        DIR_RIGHT  = 1'b1;
  localparam logic [31:0] DWELL_LOAD = DWELL_CYCLES;

  state_t      state;
  logic [1:0]  mode_q;
  logic        dir;
  logic        stop_pend;
  logic [31:0] dwell_cnt;
  logic [18:0] step;
  logic        unused_rd;

  // Next {dir, pattern} for the latched mode; ping-pong bounces off the end bits.
  function automatic logic [18:0] next_step(input logic [1:0] m, input logic d,
                                            input logic [17:0] p);
    logic [18:0] r;
    r = {d, p};
    case (m)
      2'd0: r = {d, p[16:0], p[17]};
      2'd1: r = {d, p[0], p[17:1]};
      2'd2: begin
        if (d == DIR_LEFT && p[17]) begin
          r = {DIR_RIGHT, 1'b0, p[17:1]};
        end else if (d == DIR_RIGHT && p[0]) begin
          r = {DIR_LEFT, p[16:0], 1'b0};
        end else if (d == DIR_LEFT) begin
          r = {d, p[16:0], 1'b0};
        end else begin
          r = {d, 1'b0, p[17:1]};
        end
      end
      2'd3: r = {d, p + 18'd1};
      default: r = {d, p};
    endcase
    return r;
  endfunction

  assign step = next_step(mode_q, dir, pattern);

`ifdef LEDR_SEQ_READBACK_EN
  assign unused_rd = ^avm_readdata[31:18];
`else
  assign unused_rd  = ^avm_readdata;
  assign avm_read_n = 1'b1;
  assign err        = 1'b0;
`endif

  // Sequencer FSM; every bus and status output is a register
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_address    <= 2'd0;
      avm_writedata  <= 32'd0;
      pattern        <= 18'd0;
      busy           <= 1'b0;
      dir            <= DIR_LEFT;
      dwell_cnt      <= 32'd0;
      stop_pend      <= 1'b0;
      mode_q         <= 2'd0;
`ifdef LEDR_SEQ_READBACK_EN
      avm_read_n     <= 1'b1;
      err            <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state          <= WRITE;
            busy           <= 1'b1;
            pattern        <= seed;
            mode_q         <= mode;
            dir            <= DIR_LEFT;
            stop_pend      <= 1'b0;
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
            avm_address    <= PIO_ADDR;
            avm_writedata  <= {14'd0, seed};
`ifdef LEDR_SEQ_READBACK_EN
            err            <= 1'b0;
`endif
          end else begin
            state <= IDLE;
          end
        end
        WRITE: begin
          if (!avm_waitrequest) begin
            avm_write_n <= 1'b1;
            if (stop || stop_pend) begin
              state          <= IDLE;
              busy           <= 1'b0;
              avm_chipselect <= 1'b0;
              stop_pend      <= 1'b0;
            end else begin
`ifdef LEDR_SEQ_READBACK_EN
              state      <= READ;
              avm_read_n <= 1'b0;
`else
              state          <= DWELL;
              avm_chipselect <= 1'b0;
              dwell_cnt      <= DWELL_LOAD;
`endif
            end
          end else if (stop) begin
            stop_pend <= 1'b1;
          end
        end
`ifdef LEDR_SEQ_READBACK_EN
        READ: begin
          if (!avm_waitrequest) begin
            avm_read_n     <= 1'b1;
            avm_chipselect <= 1'b0;
            if (avm_readdata[17:0] != pattern) begin
              err <= 1'b1;
            end
            if (stop || stop_pend) begin
              state     <= IDLE;
              busy      <= 1'b0;
              stop_pend <= 1'b0;
            end else begin
              state     <= DWELL;
              dwell_cnt <= DWELL_LOAD;
            end
          end else if (stop) begin
            stop_pend <= 1'b1;
          end
        end
`endif
        DWELL: begin
          if (stop) begin
            state     <= IDLE;
            busy      <= 1'b0;
            dwell_cnt <= 32'd0;
          end else if (dwell_cnt <= 32'd1) begin
            state          <= WRITE;
            pattern        <= step[17:0];
            dir            <= step[18];
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
            avm_address    <= PIO_ADDR;
            avm_writedata  <= {14'd0, step[17:0]};
          end else begin
            dwell_cnt <= dwell_cnt - 32'd1;
          end
        end
        default: begin
          state          <= IDLE;
          busy           <= 1'b0;
          avm_chipselect <= 1'b0;
          avm_write_n    <= 1'b1;
`ifdef LEDR_SEQ_READBACK_EN
          avm_read_n     <= 1'b1;
`endif
        end
      endcase
    end
  end

endmodule
